// File: rtl/fir_stream_driver.sv
// fir_stream_driver: initiator side of the FIR sample handshake.
// Takes one upstream sample at a time and presents it to the FIR with a one-cycle valid pulse.
// It waits for the FIR result, then rescales and saturates that result back to sample width.
// The result is delivered on a downstream ready/valid stream.
module fir_stream_driver #(
    parameter int unsigned WIDTH_IN  = 16,
    parameter int unsigned WIDTH_OUT = 38,
    parameter int unsigned SHIFT     = 15,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH_IN-1:0]  s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [WIDTH_IN-1:0]  fir_in,
    output logic                 fir_in_valid,
    input  logic [WIDTH_OUT-1:0] fir_out,
    input  logic                 fir_out_valid,
    output logic [WIDTH_IN-1:0]  m_data,
    output logic                 m_sat,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 timeout_err,
    output logic [15:0]          done_count
);

    // The wait counter only has to reach TIMEOUT-1.
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    // Sample-width saturation limits, sign-extended to the FIR output width.
    localparam logic signed [WIDTH_OUT-1:0] SAT_MAX =
        {{(WIDTH_OUT-WIDTH_IN+1){1'b0}}, {(WIDTH_IN-1){1'b1}}};
    localparam logic signed [WIDTH_OUT-1:0] SAT_MIN =
        {{(WIDTH_OUT-WIDTH_IN+1){1'b1}}, {(WIDTH_IN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_t;

    state_t              state_q, state_d;
    logic [WIDTH_IN-1:0] fir_in_q, fir_in_d;
    logic [WIDTH_IN-1:0] m_data_q, m_data_d;
    logic                m_sat_q, m_sat_d;
    logic                timeout_err_q, timeout_err_d;
    logic [15:0]         done_count_q, done_count_d;
    logic [CNT_W-1:0]    wait_q, wait_d;

    logic signed [WIDTH_OUT-1:0] scaled;
    logic [WIDTH_IN-1:0]         sat_data;
    logic                        sat_flag;

    // Rescale the FIR result (floor shift) and clip it to the signed sample range.
    always_comb begin
        scaled   = $signed(fir_out) >>> SHIFT;
        sat_data = scaled[WIDTH_IN-1:0];
        sat_flag = 1'b0;
        if (scaled > SAT_MAX) begin
            sat_data = {1'b0, {(WIDTH_IN-1){1'b1}}};
            sat_flag = 1'b1;
        end else if (scaled < SAT_MIN) begin
            sat_data = {1'b1, {(WIDTH_IN-1){1'b0}}};
            sat_flag = 1'b1;
        end
    end

    // Next-state and datapath updates for the one-sample-in-flight handshake.
    always_comb begin
        state_d       = state_q;
        fir_in_d      = fir_in_q;
        m_data_d      = m_data_q;
        m_sat_d       = m_sat_q;
        timeout_err_d = timeout_err_q;
        done_count_d  = done_count_q;
        wait_d        = wait_q;
        unique case (state_q)
            StIdle: begin
                if (s_valid) begin
                    fir_in_d = s_data;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                wait_d  = '0;
                state_d = StWait;
            end
            StWait: begin
                // A result in the last wait cycle still beats the timeout.
                if (fir_out_valid) begin
                    m_data_d = sat_data;
                    m_sat_d  = sat_flag;
                    state_d  = StHold;
                end else if (wait_q == CNT_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = StIdle;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            StHold: begin
                if (m_ready) begin
                    done_count_d = done_count_q + 16'd1;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; async reset discards any in-flight work.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            fir_in_q      <= '0;
            m_data_q      <= '0;
            m_sat_q       <= 1'b0;
            timeout_err_q <= 1'b0;
            done_count_q  <= '0;
            wait_q        <= '0;
        end else begin
            state_q       <= state_d;
            fir_in_q      <= fir_in_d;
            m_data_q      <= m_data_d;
            m_sat_q       <= m_sat_d;
            timeout_err_q <= timeout_err_d;
            done_count_q  <= done_count_d;
            wait_q        <= wait_d;
        end
    end

    assign s_ready      = (state_q == StIdle);
    assign fir_in_valid = (state_q == StIssue);
    assign m_valid      = (state_q == StHold);
    assign fir_in       = fir_in_q;
    assign m_data       = m_data_q;
    assign m_sat        = m_sat_q;
    assign timeout_err  = timeout_err_q;
    assign done_count   = done_count_q;

endmodule

// File: tb/tb_fir_stream_driver.sv
// Bench for fir_stream_driver: scoreboard of expected results, one task per scenario.
module tb_fir_stream_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    // Main instance (TIMEOUT = 255)
    logic [15:0] s_data;
    logic        s_valid, s_ready;
    logic [15:0] fir_in;
    logic        fir_in_valid;
    logic [37:0] fir_out;
    logic        fir_out_valid;
    logic [15:0] m_data;
    logic        m_sat, m_valid, m_ready, timeout_err;
    logic [15:0] done_count;
    // Short-timeout instance (TIMEOUT = 10)
    logic [15:0] t_s_data;
    logic        t_s_valid, t_s_ready;
    logic [15:0] t_fir_in;
    logic        t_fir_in_valid;
    logic [37:0] t_fir_out;
    logic        t_fir_out_valid;
    logic [15:0] t_m_data;
    logic        t_m_sat, t_m_valid, t_m_ready, t_timeout_err;
    logic [15:0] t_done_count;

    fir_stream_driver dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .fir_in(fir_in), .fir_in_valid(fir_in_valid), .fir_out(fir_out),
        .fir_out_valid(fir_out_valid), .m_data(m_data), .m_sat(m_sat), .m_valid(m_valid),
        .m_ready(m_ready), .timeout_err(timeout_err), .done_count(done_count)
    );

    fir_stream_driver #(.TIMEOUT(10)) dut_to (
        .clk(clk), .rst(rst), .s_data(t_s_data), .s_valid(t_s_valid), .s_ready(t_s_ready),
        .fir_in(t_fir_in), .fir_in_valid(t_fir_in_valid), .fir_out(t_fir_out),
        .fir_out_valid(t_fir_out_valid), .m_data(t_m_data), .m_sat(t_m_sat),
        .m_valid(t_m_valid), .m_ready(t_m_ready), .timeout_err(t_timeout_err),
        .done_count(t_done_count)
    );

    typedef struct packed {
        logic [15:0] data;
        logic        sat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   exp_done = 0;

    // Observations recorded by the driver tasks, judged by the calling test.
    logic        obs_hs_ok, obs_fiv1, obs_fiv2, obs_mv_pre, obs_mv, obs_take_ok;
    logic        obs_sready_after, obs_mv_after;
    logic [15:0] obs_fir_in, obs_fir_in_hold, got_d;
    logic        got_s;

    // Reference: floor shift by 15, clip to signed 16-bit.
    function automatic exp_t model(input logic [37:0] fo);
        longint v;
        exp_t   e;
        v = longint'($signed(fo)) >>> 15;
        if (v > 32767)       e = '{data: 16'h7FFF, sat: 1'b1};
        else if (v < -32768) e = '{data: 16'h8000, sat: 1'b1};
        else                 e = '{data: v[15:0], sat: 1'b0};
        return e;
    endfunction

    // Handshake one sample upstream, then answer as the FIR after lat extra WAIT cycles.
    task automatic send_and_respond(input logic [15:0] sd, input logic [37:0] fo,
                                    input int lat);
        int n = 0;
        @(negedge clk);
        s_data  = sd;
        s_valid = 1'b1;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        obs_hs_ok = s_ready;
        @(negedge clk);
        s_valid    = 1'b0;
        obs_fiv1   = fir_in_valid;
        obs_fir_in = fir_in;
        @(negedge clk);
        obs_fiv2        = fir_in_valid;
        obs_fir_in_hold = fir_in;
        repeat (lat) @(negedge clk);
        obs_mv_pre    = m_valid;
        fir_out       = fo;
        fir_out_valid = 1'b1;
        @(negedge clk);
        fir_out_valid = 1'b0;
        obs_mv        = m_valid;
    endtask

    // Accept the pending downstream result (bounded wait).
    task automatic take_result();
        int n = 0;
        m_ready = 1'b1;
        while (!m_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        obs_take_ok = m_valid;
        got_d = m_data;
        got_s = m_sat;
        @(negedge clk);
        m_ready          = 1'b0;
        obs_sready_after = s_ready;
        obs_mv_after     = m_valid;
        if (obs_take_ok) exp_done++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({s_ready, fir_in_valid, m_valid, m_sat, timeout_err} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=10000",
                     {s_ready, fir_in_valid, m_valid, m_sat, timeout_err});
        end
        total++;
        if ({fir_in, m_data, done_count} !== 48'h0) begin
            bad++;
            $display("FAIL reset_data got=%h exp=0", {fir_in, m_data, done_count});
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (t_s_ready !== 1'b1 || t_timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_to_inst got=%b%b exp=10", t_s_ready, t_timeout_err);
        end
    endtask

    task automatic test_nominal();
        exp_t e, g;
        sb.push_back('{data: 16'h03E8, sat: 1'b0});
        send_and_respond(16'h03E8, 38'(longint'(1000) <<< 15), 99);
        total++;
        if (obs_hs_ok !== 1'b1) begin bad++; $display("FAIL nom_handshake got=%b exp=1", obs_hs_ok); end
        total++;
        if (obs_fiv1 !== 1'b1 || obs_fir_in !== 16'h03E8) begin
            bad++;
            $display("FAIL nom_issue got=%b/%h exp=1/03e8", obs_fiv1, obs_fir_in);
        end
        total++;
        if (obs_fiv2 !== 1'b0) begin bad++; $display("FAIL nom_pulse_width got=%b exp=0", obs_fiv2); end
        total++;
        if (obs_mv_pre !== 1'b0 || obs_mv !== 1'b1) begin
            bad++;
            $display("FAIL nom_mvalid_latency got=%b%b exp=01", obs_mv_pre, obs_mv);
        end
        take_result();
        g = '{data: got_d, sat: got_s};
        e = sb.pop_front();
        total++;
        if (g !== e) begin bad++; $display("FAIL nom_result got=%h exp=%h", g, e); end
        total++;
        if (done_count !== 16'd1) begin bad++; $display("FAIL nom_done got=%0d exp=1", done_count); end
        total++;
        if (obs_sready_after !== 1'b1 || obs_mv_after !== 1'b0) begin
            bad++;
            $display("FAIL nom_after got=%b%b exp=10", obs_sready_after, obs_mv_after);
        end
    endtask

    // Negative result and both saturation directions.
    task automatic test_signs_and_saturation();
        logic [37:0] fos[3];
        exp_t        exps[3];
        exp_t        e, g;
        fos[0] = 38'(-(longint'(5) <<< 15));     exps[0] = '{data: 16'hFFFB, sat: 1'b0};
        fos[1] = 38'(longint'(40000) <<< 15);    exps[1] = '{data: 16'h7FFF, sat: 1'b1};
        fos[2] = 38'(-(longint'(40000) <<< 15)); exps[2] = '{data: 16'h8000, sat: 1'b1};
        for (int i = 0; i < 3; i++) begin
            sb.push_back(exps[i]);
            send_and_respond(16'h0100 + 16'(i), fos[i], 2 + i);
            take_result();
            g = '{data: got_d, sat: got_s};
            e = sb.pop_front();
            total++;
            if (g !== e) begin bad++; $display("FAIL sat_case%0d got=%h exp=%h", i, g, e); end
            total++;
            if (done_count !== 16'(exp_done)) begin
                bad++;
                $display("FAIL sat_done%0d got=%0d exp=%0d", i, done_count, exp_done);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t e, g;
        sb.push_back('{data: 16'h0123, sat: 1'b0});
        send_and_respond(16'h0AAA, 38'(longint'(16'h0123) <<< 15), 1);
        for (int i = 0; i < 5; i++) begin
            m_ready = 1'b0;
            s_data  = 16'h5555;
            s_valid = 1'b1;
            @(negedge clk);
            total++;
            if (m_data !== 16'h0123 || m_valid !== 1'b1 || s_ready !== 1'b0 ||
                fir_in_valid !== 1'b0 || fir_in !== 16'h0AAA) begin
                bad++;
                $display("FAIL bp_hold%0d got=%h/%b/%b/%b/%h exp=0123/1/0/0/0aaa", i, m_data,
                         m_valid, s_ready, fir_in_valid, fir_in);
            end
        end
        s_valid = 1'b0;
        take_result();
        g = '{data: got_d, sat: got_s};
        e = sb.pop_front();
        total++;
        if (g !== e) begin bad++; $display("FAIL bp_result got=%h exp=%h", g, e); end
        total++;
        if (obs_sready_after !== 1'b1) begin
            bad++;
            $display("FAIL bp_sready_next got=%b exp=1", obs_sready_after);
        end
        total++;
        if (done_count !== 16'(exp_done)) begin
            bad++;
            $display("FAIL bp_done got=%0d exp=%0d", done_count, exp_done);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            longint      val;
            logic [37:0] fo;
            logic [15:0] sd;
            exp_t        e, g;
            val = longint'($urandom_range(0, 50000)) * 32768 + longint'($urandom_range(0, 32767));
            if ($urandom_range(0, 1) == 1) val = -val;
            fo = val[37:0];
            sd = 16'($urandom);
            sb.push_back(model(fo));
            send_and_respond(sd, fo, int'($urandom_range(0, 6)));
            total++;
            if (obs_fir_in !== sd || obs_fir_in_hold !== sd) begin
                bad++;
                $display("FAIL rnd_fir_in%0d got=%h/%h exp=%h", i, obs_fir_in, obs_fir_in_hold, sd);
            end
            take_result();
            g = '{data: got_d, sat: got_s};
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL rnd_sb_empty%0d got=0 exp=1", i);
            end else begin
                e = sb.pop_front();
                if (g !== e) begin
                    bad++;
                    $display("FAIL rnd_result%0d fo=%h got=%h exp=%h", i, fo, g, e);
                end
            end
        end
    endtask

    task automatic test_timeout();
        logic seen;
        // Sample A: FIR answers in the 10th (last) WAIT cycle and must win.
        @(negedge clk);
        t_s_data  = 16'h0011;
        t_s_valid = 1'b1;
        @(negedge clk);
        t_s_valid = 1'b0;
        repeat (10) @(negedge clk);
        t_fir_out       = 38'(longint'(17) <<< 15);
        t_fir_out_valid = 1'b1;
        @(negedge clk);
        t_fir_out_valid = 1'b0;
        total++;
        if (t_m_valid !== 1'b1 || t_timeout_err !== 1'b0 || t_m_data !== 16'h0011) begin
            bad++;
            $display("FAIL to_last_cycle_wins got=%b/%b/%h exp=1/0/0011", t_m_valid,
                     t_timeout_err, t_m_data);
        end
        t_m_ready = 1'b1;
        @(negedge clk);
        t_m_ready = 1'b0;
        // Sample B: FIR never answers.
        t_s_data  = 16'h0022;
        t_s_valid = 1'b1;
        @(negedge clk);
        t_s_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen = seen | t_timeout_err | t_m_valid | t_s_ready;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL to_early got=%b exp=0", seen); end
        @(negedge clk);
        total++;
        if (t_timeout_err !== 1'b1 || t_s_ready !== 1'b1 || t_m_valid !== 1'b0 ||
            t_done_count !== 16'd1) begin
            bad++;
            $display("FAIL to_expire got=%b/%b/%b/%0d exp=1/1/0/1", t_timeout_err, t_s_ready,
                     t_m_valid, t_done_count);
        end
        // Sample C: completes normally; the error flag stays sticky.
        t_s_data  = 16'h0033;
        t_s_valid = 1'b1;
        @(negedge clk);
        t_s_valid = 1'b0;
        @(negedge clk);
        t_fir_out       = 38'(-(longint'(3) <<< 15));
        t_fir_out_valid = 1'b1;
        @(negedge clk);
        t_fir_out_valid = 1'b0;
        t_m_ready       = 1'b1;
        total++;
        if (t_m_valid !== 1'b1 || t_m_data !== 16'hFFFD || t_m_sat !== 1'b0) begin
            bad++;
            $display("FAIL to_second got=%b/%h/%b exp=1/fffd/0", t_m_valid, t_m_data, t_m_sat);
        end
        @(negedge clk);
        t_m_ready = 1'b0;
        total++;
        if (t_done_count !== 16'd2 || t_timeout_err !== 1'b1) begin
            bad++;
            $display("FAIL to_sticky got=%0d/%b exp=2/1", t_done_count, t_timeout_err);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic seen;
        @(negedge clk);
        s_data  = 16'h0ABC;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({s_ready, fir_in_valid, m_valid, m_sat, timeout_err} !== 5'b10000 ||
            {fir_in, m_data, done_count} !== 48'h0) begin
            bad++;
            $display("FAIL async_reset got=%b/%h exp=10000/0",
                     {s_ready, fir_in_valid, m_valid, m_sat, timeout_err},
                     {fir_in, m_data, done_count});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fir_out       = 38'(longint'(99) <<< 15);
        fir_out_valid = 1'b1;
        @(negedge clk);
        fir_out_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen = seen | m_valid | ~s_ready;
            @(negedge clk);
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL late_fir_ignored got=%b exp=0", seen); end
    endtask

    initial begin
        s_data = '0; s_valid = 1'b0; fir_out = '0; fir_out_valid = 1'b0; m_ready = 1'b0;
        t_s_data = '0; t_s_valid = 1'b0; t_fir_out = '0; t_fir_out_valid = 1'b0;
        t_m_ready = 1'b0;
        test_reset();
        test_nominal();
        test_signs_and_saturation();
        test_backpressure();
        test_random();
        test_timeout();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
